gshare_branch_predictor: RTL

GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

---
 rtl/gshare_branch_predictor.sv | 78 +++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: BTB plus global-history-XOR PHT, predicting next fetch PC combinationally
module gshare_branch_predictor #(
  parameter int INDEX_BITS = 5,
  parameter int HIST_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          if_pc,
  output logic                 pred_taken,
  output logic [31:0]          next_pc,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  logic                 upd_is_ctrl,
  input  logic                 upd_is_cond,
  input  logic [31:0]          upd_pc,
  input  logic [HIST_BITS-1:0] upd_hist,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_mispredict,
  output logic [31:0]          upd_count,
  output logic [31:0]          mispred_count
);
  localparam int N  = 1 << INDEX_BITS;
  localparam int TW = 30 - INDEX_BITS;
  if (INDEX_BITS < 2 || INDEX_BITS > 10 || HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_params
    $error("gshare_branch_predictor: illegal INDEX_BITS/HIST_BITS");
  end
  logic                 btb_valid  [N];
  logic                 btb_uncond [N];
  logic [TW-1:0]        btb_tag    [N];
  logic [31:0]          btb_target [N];
  logic [1:0]           pht        [N];
  logic [HIST_BITS-1:0] bhr;
  logic [INDEX_BITS-1:0] fi, pi, ui, uj;
  logic hit, accept;
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
  always_comb begin
    fi = if_pc[INDEX_BITS+1:2];
    pi = fi ^ INDEX_BITS'(bhr);
    ui = upd_pc[INDEX_BITS+1:2];
    uj = ui ^ INDEX_BITS'(upd_hist);
    hit = btb_valid[fi] && btb_tag[fi] == if_pc[31:INDEX_BITS+2];
    pred_taken = hit && (btb_uncond[fi] || pht[pi][1]);
    next_pc = pred_taken ? btb_target[fi] : if_pc + 32'd4;
    pred_hist = bhr;
    accept = upd_valid && upd_is_ctrl;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_uncond[i] <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        pht[i]        <= 2'b01;
      end
      bhr           <= '0;
      upd_count     <= '0;
      mispred_count <= '0;
    end else if (accept) begin
      if (upd_taken) begin
        btb_valid[ui]  <= 1'b1;
        btb_uncond[ui] <= !upd_is_cond;
        btb_tag[ui]    <= upd_pc[31:INDEX_BITS+2];
        btb_target[ui] <= upd_target;
      end
      if (upd_is_cond) begin
        pht[uj] <= upd_taken ? (pht[uj] == 2'b11 ? 2'b11 : pht[uj] + 2'b01)
                             : (pht[uj] == 2'b00 ? 2'b00 : pht[uj] - 2'b01);
        // truncation keeps the low bits, so HIST_BITS=1 simply loads the outcome
        bhr <= HIST_BITS'({bhr, upd_taken});
      end
      upd_count <= upd_count + {31'd0, ~&upd_count};
      if (upd_mispredict) mispred_count <= mispred_count + {31'd0, ~&mispred_count};
    end
  end
endmodule
